pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit for the 5-stage core (IF/ID/EX/MEM/WB). Generates per-stage stall/flush,
//  owns the control registers read by the ID decoder (RDCR) and written by WRCR, sequences
//  exception entry/return (EXRT), and tracks KERNEL/USER mode. Exceptions are committed at MEM.
// PARAMETERS
//  IRQ_W      8    number of external interrupt lines
//  CREG_NUM   6    implemented control registers (addresses 0..5); others read 0, writes ignored
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  reset_         in   1   asynchronous, active-low reset
//  creg_rd_addr   in   5   control-register read address from ID (ra field)
//  creg_rd_data   out  32  control-register read data to ID
//  exe_mode       out  1   current mode: 0=KERNEL, 1=USER
//  irq            in   IRQ_W  level-sensitive external interrupt requests
//  int_detect     out  1   unmasked interrupt pending and enabled
//  if_busy        in   1   IF bus access not complete
//  ld_hazard      in   1   load-use hazard flagged by ID
//  mem_busy       in   1   MEM bus access not complete
//  id_pc          in   30  word PC of instruction in ID (interrupt return point)
//  mem_en         in   1   MEM-stage instruction valid
//  mem_pc         in   30  word PC of instruction in MEM
//  mem_br_flag    in   1   MEM instruction is a branch/jump
//  mem_ctrl_op    in   2   NOP / WRCR / EXRT
//  mem_dst_addr   in   5   WRCR target control-register address
//  mem_exp_code   in   3   exception code carried to MEM
//  mem_out        in   32  WRCR write data
//  if/id/ex/mem_stall  out 1 each  hold stage register
//  if/id/ex/mem_flush  out 1 each  invalidate stage register
//  new_pc         out  30  redirect target, valid when if_flush=1
// BEHAVIOUR
//  - Creg map: 0 STATUS{int_en[1],exe_mode[0]}; 1 PRE_STATUS{pre_int_en,pre_exe_mode};
//    2 INT_MASK[IRQ_W-1:0] (1=masked); 3 EXP_CODE{br_flag[3],code[2:0]}; 4 EXP_VECTOR[31:2];
//    5 EPC[31:2]. Word-address regs read back as {addr,2'b00}. Unused bits read 0.
//  - Reset (async, reset_=0): exe_mode=KERNEL, int_en=0, pre_*=0, INT_MASK=all 1s, EXP_CODE=0,
//    EXP_VECTOR=0, EPC=0. All stall/flush outputs 0, new_pc=0 while reset asserted.
//  - Stall (combinational): stall=if_busy|mem_busy; if_stall=stall|ld_hazard; id/ex/mem_stall=stall.
//  - ld_hazard without stall: id_flush=1 (bubble into EX), IF holds.
//  - int_detect = int_en & |(irq & ~INT_MASK). Taken only when mem_en=1, mem_exp_code=NO_EXP,
//    mem_stall=0; treated as code EXT_INT with EPC=id_pc (MEM instr completes).
//  - Exception (mem_en & code!=NO_EXP & !mem_stall): same cycle flush all four stages,
//    new_pc=EXP_VECTOR. Next edge: EPC<=mem_pc, EXP_CODE<={mem_br_flag,code}, PRE_STATUS<=STATUS,
//    exe_mode<=KERNEL, int_en<=0. MEM instruction does not commit.
//  - EXRT at MEM (no exception, !mem_stall): flush all stages, new_pc=EPC; next edge
//    STATUS<=PRE_STATUS.
//  - WRCR at MEM (no exception, !mem_stall): creg[mem_dst_addr]<=mem_out next edge; then flush
//    IF/ID/EX with new_pc=mem_pc+1 so younger instrs see new mode/mask.
//  - Priority: reset > mem_stall (freezes all creg updates, no flush) > exception > interrupt >
//    EXRT > WRCR. mem_en=0 -> no creg update, no flush.
//  - Read bypass: WRCR committing this cycle with mem_dst_addr==creg_rd_addr returns mem_out.
//  - Mode FSM: KERNEL->USER only via EXRT/WRCR of STATUS; USER->KERNEL on any exception/interrupt.
//  - new_pc=0 whenever no flush; 30-bit PC add wraps modulo 2^30.
// STRUCTURE
//  - Exception codes, CTRL_OP_*, creg addresses, CPU_KERNEL/USER_MODE live in shared cpu.h/isa.h.
//  - One natural sub-module: pipe_ctrl_creg (control-register file with bypass read); rest flat.
// TESTING
//  - Reset: reset_=0 mid-run -> exe_mode=0, INT_MASK reads 32'h000000FF, all flush/stall 0.
//  - TRAP (code 5) at MEM, mem_pc=30'h100, EXP_VECTOR=30'h40 -> flush all, new_pc=30'h40;
//    next read EPC=32'h400, EXP_CODE=5, exe_mode=KERNEL.
//  - WRCR STATUS=1 then EXRT with EPC=30'h200 -> new_pc=30'h200, exe_mode restored from PRE_STATUS.
//  - irq=8'h01, INT_MASK=8'hFE, int_en=1, id_pc=30'h55 -> int_detect=1, EXP_CODE=1, EPC=32'h154.
//  - mem_busy=1 with pending TRAP -> all stalls 1, no flush, no creg change until mem_busy=0.
//  - ld_hazard=1, busy=0 -> if_stall=1, id_flush=1, others 0; RDCR of addr 7 returns 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: exception codes, control ops,
// control-register addresses and execution modes.
package pipe_ctrl_pkg;

  localparam logic [2:0] EXP_NO_EXP      = 3'd0;
  localparam logic [2:0] EXP_EXT_INT     = 3'd1;
  localparam logic [2:0] EXP_UNDEF_INSN  = 3'd2;
  localparam logic [2:0] EXP_OVERFLOW    = 3'd3;
  localparam logic [2:0] EXP_MISS_ALIGN  = 3'd4;
  localparam logic [2:0] EXP_TRAP        = 3'd5;
  localparam logic [2:0] EXP_PRV_VIOLATE = 3'd6;

  localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

  localparam logic [4:0] CREG_STATUS     = 5'd0;
  localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
  localparam logic [4:0] CREG_INT_MASK   = 5'd2;
  localparam logic [4:0] CREG_EXP_CODE   = 5'd3;
  localparam logic [4:0] CREG_EXP_VECTOR = 5'd4;
  localparam logic [4:0] CREG_EPC        = 5'd5;

  // Mode FSM states; the current state is the exe_mode output.
  localparam logic [0:0] CPU_KERNEL_MODE = 1'b0;
  localparam logic [0:0] CPU_USER_MODE   = 1'b1;

  function automatic logic [31:0] word_to_byte(input logic [29:0] addr);
    return {addr, 2'b00};
  endfunction

endpackage

// File: rtl/pipe_ctrl_creg.sv
// Control-register file: exception entry/return sequencing, WRCR writes and a
// read port that forwards a WRCR committing in the same cycle.
module pipe_ctrl_creg
  import pipe_ctrl_pkg::*;
#(
  parameter int IRQ_W    = 8,
  parameter int CREG_NUM = 6
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [4:0]       rd_addr,
  output logic [31:0]      rd_data,
  input  logic             exp_en,
  input  logic [2:0]       exp_code_in,
  input  logic             exp_br_flag,
  input  logic [29:0]      exp_epc,
  input  logic             exrt_en,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [31:0]      wr_data,
  output logic             exe_mode,
  output logic             int_en,
  output logic [IRQ_W-1:0] int_mask,
  output logic [29:0]      exp_vector,
  output logic [29:0]      epc
);

  localparam logic [4:0] CREG_LAST = 5'(CREG_NUM - 1);

  logic       pre_exe_mode;
  logic       pre_int_en;
  logic [3:0] exp_code;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      exe_mode     <= CPU_KERNEL_MODE;
      int_en       <= 1'b0;
      pre_exe_mode <= CPU_KERNEL_MODE;
      pre_int_en   <= 1'b0;
      int_mask     <= '1;
      exp_code     <= '0;
      exp_vector   <= '0;
      epc          <= '0;
    end else if (exp_en) begin
      pre_exe_mode <= exe_mode;
      pre_int_en   <= int_en;
      exe_mode     <= CPU_KERNEL_MODE;
      int_en       <= 1'b0;
      exp_code     <= {exp_br_flag, exp_code_in};
      epc          <= exp_epc;
    end else if (exrt_en) begin
      exe_mode     <= pre_exe_mode;
      int_en       <= pre_int_en;
    end else if (wr_en) begin
      case (wr_addr)
        CREG_STATUS:     {int_en, exe_mode} <= wr_data[1:0];
        CREG_PRE_STATUS: {pre_int_en, pre_exe_mode} <= wr_data[1:0];
        CREG_INT_MASK:   int_mask <= wr_data[IRQ_W-1:0];
        CREG_EXP_CODE:   exp_code <= wr_data[3:0];
        CREG_EXP_VECTOR: exp_vector <= wr_data[31:2];
        CREG_EPC:        epc <= wr_data[31:2];
        default:         ;
      endcase
    end
  end

  // Forwarding only applies to implemented addresses; others always read 0.
  always_comb begin
    rd_data = '0;
    if (wr_en && (wr_addr == rd_addr) && (rd_addr <= CREG_LAST)) begin
      rd_data = wr_data;
    end else begin
      case (rd_addr)
        CREG_STATUS:     rd_data = {30'd0, int_en, exe_mode};
        CREG_PRE_STATUS: rd_data = {30'd0, pre_int_en, pre_exe_mode};
        CREG_INT_MASK:   rd_data = {{(32-IRQ_W){1'b0}}, int_mask};
        CREG_EXP_CODE:   rd_data = {28'd0, exp_code};
        CREG_EXP_VECTOR: rd_data = word_to_byte(exp_vector);
        CREG_EPC:        rd_data = word_to_byte(epc);
        default:         rd_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: stall/flush generation, exception and
// interrupt commit at MEM, EXRT/WRCR handling and the control-register file.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int IRQ_W    = 8,
  parameter int CREG_NUM = 6
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [4:0]       creg_rd_addr,
  output logic [31:0]      creg_rd_data,
  output logic             exe_mode,
  input  logic [IRQ_W-1:0] irq,
  output logic             int_detect,
  input  logic             if_busy,
  input  logic             ld_hazard,
  input  logic             mem_busy,
  input  logic [29:0]      id_pc,
  input  logic             mem_en,
  input  logic [29:0]      mem_pc,
  input  logic             mem_br_flag,
  input  logic [1:0]       mem_ctrl_op,
  input  logic [4:0]       mem_dst_addr,
  input  logic [2:0]       mem_exp_code,
  input  logic [31:0]      mem_out,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic [29:0]      new_pc
);

  logic             int_en;
  logic [IRQ_W-1:0] int_mask;
  logic [29:0]      exp_vector;
  logic [29:0]      epc;
  logic             stall;
  logic             commit_ok;
  logic             exp_hit;
  logic             int_hit;
  logic             exrt_hit;
  logic             wrcr_hit;

  assign stall      = if_busy | mem_busy;
  assign int_detect = int_en & (|(irq & ~int_mask));

  // One-hot commit decision at MEM in priority order; nothing commits while stalled.
  assign commit_ok = mem_en & ~stall;
  assign exp_hit   = commit_ok & (mem_exp_code != EXP_NO_EXP);
  assign int_hit   = commit_ok & (mem_exp_code == EXP_NO_EXP) & int_detect;
  assign exrt_hit  = commit_ok & (mem_exp_code == EXP_NO_EXP) & ~int_detect &
                     (mem_ctrl_op == CTRL_OP_EXRT);
  assign wrcr_hit  = commit_ok & (mem_exp_code == EXP_NO_EXP) & ~int_detect &
                     (mem_ctrl_op == CTRL_OP_WRCR);

  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if (reset_) begin
      if_stall  = stall | ld_hazard;
      id_stall  = stall;
      ex_stall  = stall;
      mem_stall = stall;
    end
  end

  // Interrupts leave MEM intact: the return point is the ID instruction.
  always_comb begin
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    new_pc    = '0;
    if (reset_ && !stall) begin
      if (exp_hit) begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc = exp_vector;
      end else if (int_hit) begin
        {if_flush, id_flush, ex_flush} = 3'b111;
        new_pc = exp_vector;
      end else if (exrt_hit) begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc = epc;
      end else if (wrcr_hit) begin
        {if_flush, id_flush, ex_flush} = 3'b111;
        new_pc = mem_pc + 30'd1;
      end else if (ld_hazard) begin
        id_flush = 1'b1;
      end
    end
  end

  pipe_ctrl_creg #(
    .IRQ_W    (IRQ_W),
    .CREG_NUM (CREG_NUM)
  ) u_creg (
    .clk         (clk),
    .reset_      (reset_),
    .rd_addr     (creg_rd_addr),
    .rd_data     (creg_rd_data),
    .exp_en      (exp_hit | int_hit),
    .exp_code_in (int_hit ? EXP_EXT_INT : mem_exp_code),
    .exp_br_flag (int_hit ? 1'b0 : mem_br_flag),
    .exp_epc     (int_hit ? id_pc : mem_pc),
    .exrt_en     (exrt_hit),
    .wr_en       (wrcr_hit),
    .wr_addr     (mem_dst_addr),
    .wr_data     (mem_out),
    .exe_mode    (exe_mode),
    .int_en      (int_en),
    .int_mask    (int_mask),
    .exp_vector  (exp_vector),
    .epc         (epc)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, exceptions, EXRT, WRCR, interrupts,
// stalls and load-use bubbles against hand-computed values.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset_;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode;
  logic [7:0]  irq;
  logic        int_detect;
  logic        if_busy;
  logic        ld_hazard;
  logic        mem_busy;
  logic [29:0] id_pc;
  logic        mem_en;
  logic [29:0] mem_pc;
  logic        mem_br_flag;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.IRQ_W(8), .CREG_NUM(6)) dut (
    .clk          (clk),
    .reset_       (reset_),
    .creg_rd_addr (creg_rd_addr),
    .creg_rd_data (creg_rd_data),
    .exe_mode     (exe_mode),
    .irq          (irq),
    .int_detect   (int_detect),
    .if_busy      (if_busy),
    .ld_hazard    (ld_hazard),
    .mem_busy     (mem_busy),
    .id_pc        (id_pc),
    .mem_en       (mem_en),
    .mem_pc       (mem_pc),
    .mem_br_flag  (mem_br_flag),
    .mem_ctrl_op  (mem_ctrl_op),
    .mem_dst_addr (mem_dst_addr),
    .mem_exp_code (mem_exp_code),
    .mem_out      (mem_out),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .ex_stall     (ex_stall),
    .mem_stall    (mem_stall),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .ex_flush     (ex_flush),
    .mem_flush    (mem_flush),
    .new_pc       (new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_en       = 1'b0;
    mem_ctrl_op  = 2'd0;
    mem_exp_code = 3'd0;
    mem_br_flag  = 1'b0;
    mem_dst_addr = 5'd0;
    mem_out      = 32'd0;
    mem_pc       = 30'd0;
    id_pc        = 30'd0;
    if_busy      = 1'b0;
    mem_busy     = 1'b0;
    ld_hazard    = 1'b0;
    irq          = 8'd0;
    creg_rd_addr = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    creg_rd_addr = addr;
    #1;
    check(tag, creg_rd_data, exp);
  endtask

  task automatic check_pipe(input logic [3:0] stl, input logic [3:0] fl,
                            input logic [29:0] npc, input string tag);
    check({tag, ".stall"}, {28'd0, if_stall, id_stall, ex_stall, mem_stall}, {28'd0, stl});
    check({tag, ".flush"}, {28'd0, if_flush, id_flush, ex_flush, mem_flush}, {28'd0, fl});
    check({tag, ".new_pc"}, {2'b00, new_pc}, {2'b00, npc});
  endtask

  task automatic wrcr(input logic [4:0] addr, input logic [31:0] data,
                      input logic [29:0] pc, input logic [29:0] exp_npc, input string tag);
    idle();
    mem_en       = 1'b1;
    mem_ctrl_op  = 2'd1;
    mem_dst_addr = addr;
    mem_out      = data;
    mem_pc       = pc;
    creg_rd_addr = addr;
    #1;
    check_pipe(4'b0000, 4'b1110, exp_npc, tag);
    check({tag, ".bypass"}, creg_rd_data, (addr <= 5'd5) ? data : 32'd0);
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset_ = 1'b0;
    if_busy = 1'b1;
    #1;
    tick();
    check("rst.exe_mode", {31'd0, exe_mode}, 32'd0);
    check_pipe(4'b0000, 4'b0000, 30'd0, "rst");
    rd(5'd2, 32'h0000_00FF, "rst.int_mask");
    idle();
    @(negedge clk);
    reset_ = 1'b1;
    tick();

    // EXP_VECTOR <= 30'h40
    wrcr(5'd4, 32'h0000_0100, 30'h10, 30'h11, "wr_vec");
    rd(5'd4, 32'h0000_0100, "vec.read");
    check_pipe(4'b0000, 4'b0000, 30'd0, "idle");

    // TRAP at MEM
    mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h100;
    #1;
    check_pipe(4'b0000, 4'b1111, 30'h40, "trap");
    tick(); idle();
    rd(5'd5, 32'h0000_0400, "trap.epc");
    rd(5'd3, 32'h0000_0005, "trap.code");
    check("trap.mode", {31'd0, exe_mode}, 32'd0);

    // Pending trap frozen by mem_busy
    mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h3FF; mem_br_flag = 1'b1; mem_busy = 1'b1;
    #1;
    check_pipe(4'b1111, 4'b0000, 30'd0, "busy");
    tick(); tick();
    rd(5'd5, 32'h0000_0400, "busy.epc");
    rd(5'd3, 32'h0000_0005, "busy.code");
    mem_busy = 1'b0;
    #1;
    check_pipe(4'b0000, 4'b1111, 30'h40, "unbusy");
    tick(); idle();
    rd(5'd5, 32'h0000_0FFC, "unbusy.epc");
    rd(5'd3, 32'h0000_000D, "unbusy.code");

    // STATUS=USER (PC wraps), trap back to KERNEL, then EXRT to 30'h200
    wrcr(5'd0, 32'h1, 30'h3FFF_FFFF, 30'h0, "wr_status");
    check("user.mode", {31'd0, exe_mode}, 32'd1);
    mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h20;
    #1; tick(); idle();
    check("trap2.mode", {31'd0, exe_mode}, 32'd0);
    rd(5'd1, 32'h0000_0001, "trap2.pre");
    wrcr(5'd5, 32'h0000_0800, 30'h30, 30'h31, "wr_epc");
    mem_en = 1'b1; mem_ctrl_op = 2'd2;
    #1;
    check_pipe(4'b0000, 4'b1111, 30'h200, "exrt");
    tick(); idle();
    check("exrt.mode", {31'd0, exe_mode}, 32'd1);
    rd(5'd0, 32'h0000_0001, "exrt.status");

    // Interrupt
    wrcr(5'd2, 32'h0000_00FE, 30'h40, 30'h41, "wr_mask");
    wrcr(5'd0, 32'h0000_0002, 30'h50, 30'h51, "wr_int_en");
    irq = 8'h02;
    #1;
    check("irq.masked", {31'd0, int_detect}, 32'd0);
    irq = 8'h01;
    #1;
    check("irq.detect", {31'd0, int_detect}, 32'd1);
    check_pipe(4'b0000, 4'b0000, 30'd0, "irq.no_en");
    mem_en = 1'b1; id_pc = 30'h55; mem_pc = 30'h60;
    #1;
    check_pipe(4'b0000, 4'b1110, 30'h40, "irq.take");
    tick();
    irq = 8'h01; mem_en = 1'b0;
    #1;
    check("irq.cleared", {31'd0, int_detect}, 32'd0);
    rd(5'd3, 32'h0000_0001, "irq.code");
    rd(5'd5, 32'h0000_0154, "irq.epc");
    rd(5'd1, 32'h0000_0002, "irq.pre");
    idle();

    // Load-use bubble and unimplemented address
    ld_hazard = 1'b1;
    #1;
    check_pipe(4'b1000, 4'b0100, 30'd0, "ldh");
    rd(5'd7, 32'd0, "rd7");
    idle();
    wrcr(5'd7, 32'h0000_DEAD, 30'h70, 30'h71, "wr7");
    rd(5'd7, 32'd0, "rd7.after");

    // Reset mid-run
    wrcr(5'd0, 32'h1, 30'h80, 30'h81, "wr_user");
    mem_en = 1'b1; mem_exp_code = 3'd5; if_busy = 1'b1; ld_hazard = 1'b1;
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    check("rst2.mode", {31'd0, exe_mode}, 32'd0);
    check_pipe(4'b0000, 4'b0000, 30'd0, "rst2");
    rd(5'd2, 32'h0000_00FF, "rst2.mask");
    rd(5'd5, 32'd0, "rst2.epc");
    reset_ = 1'b1;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
